// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - protobuf field types, varint limits, decoder states and type post-processing
package pb_pkg;

  localparam logic [4:0] PB_INT64  = 5'd3;
  localparam logic [4:0] PB_UINT64 = 5'd4;
  localparam logic [4:0] PB_INT32  = 5'd5;
  localparam logic [4:0] PB_BOOL   = 5'd8;
  localparam logic [4:0] PB_UINT32 = 5'd13;
  localparam logic [4:0] PB_ENUM   = 5'd14;
  localparam logic [4:0] PB_SINT32 = 5'd17;
  localparam logic [4:0] PB_SINT64 = 5'd18;

  localparam int MAX_VARINT_BYTES = 10;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    WAIT1,
    RD2,
    WAIT2,
    FIN
  } dec_state_t;

  // Maps the assembled 64-bit group value onto the field's wire semantics.
  function automatic logic [63:0] pb_post_process(input logic [63:0] raw, input logic [4:0] ftype);
    logic [31:0] lo;
    logic [31:0] zz;
    lo = raw[31:0];
    zz = (lo >> 1) ^ {32{lo[0]}};
    case (ftype)
      PB_INT64, PB_UINT64: return raw;
      PB_INT32, PB_ENUM:   return {{32{lo[31]}}, lo};
      PB_UINT32:           return {32'b0, lo};
      PB_SINT64:           return (raw >> 1) ^ {64{raw[0]}};
      PB_SINT32:           return {{32{zz[31]}}, zz};
      PB_BOOL:             return {63'b0, |raw};
      default:             return raw;
    endcase
  endfunction

endpackage

// File: rtl/varint_assemble.sv
// rtl/varint_assemble.sv - combinational varint group assembly with length and overflow detection
module varint_assemble
  import pb_pkg::*;
(
  input  logic [MAX_VARINT_BYTES-1:0][7:0] bytes,
  output logic [63:0]                      raw,
  output logic [3:0]                       len,
  output logic                             malformed
);

  logic found;

  always_comb begin
    raw   = '0;
    len   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_VARINT_BYTES; k++) begin
      if (!found) begin
        // The tenth group lands at bit 63; its upper bits fall off the 64-bit result.
        raw = raw | ({57'b0, bytes[k][6:0]} << (7 * k));
        if (!bytes[k][7]) begin
          found = 1'b1;
          len   = 4'(k + 1);
        end
      end
    end
    malformed = !found ||
                ((len == 4'(MAX_VARINT_BYTES)) && (bytes[MAX_VARINT_BYTES-1][6:1] != 6'b0));
  end

endmodule

// File: rtl/top_varint_decode.sv
// rtl/top_varint_decode.sv - protobuf varint reader over the 8-lane DRAM read port
module top_varint_decode
  import pb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_BYTES  = MAX_VARINT_BYTES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [ADDR_WIDTH-1:0]      src_addr,
  input  logic [4:0]                 field_type,
  output logic [7:0]                 dram_en,
  output logic [7:0][ADDR_WIDTH-1:0] dram_addr,
  output logic                       dram_rdwr,
  input  logic [7:0][7:0]            dram_data,
  input  logic [7:0]                 dram_valid,
  output logic [63:0]                value,
  output logic [3:0]                 bytes_read,
  output logic                       done,
  output logic                       error
);

  dec_state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      src_q;
  logic [4:0]                 type_q;
  logic [7:0][7:0]            byte_q;
  logic [MAX_BYTES-1:0][7:0]  asm_bytes;
  logic [63:0]                raw;
  logic [3:0]                 len;
  logic                       malformed;
  logic                       first_all_valid;
  logic                       last_all_valid;
  logic                       term_in_first;
  logic                       result_load;

  assign first_all_valid = (state_q == WAIT1) && (&dram_valid);
  assign last_all_valid  = (state_q == WAIT2) && (&dram_valid[1:0]);
  assign result_load     = (first_all_valid && term_in_first) || last_all_valid;
  assign dram_rdwr       = 1'b0;

  always_comb begin
    term_in_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!dram_data[i][7]) term_in_first = 1'b1;
    end
  end

  // Results are assembled from the live lanes on the capture cycle so they are valid with done.
  always_comb begin
    asm_bytes = '0;
    if (state_q == WAIT2) begin
      asm_bytes[7:0] = byte_q;
      asm_bytes[8]   = dram_data[0];
      asm_bytes[9]   = dram_data[1];
    end else begin
      asm_bytes[7:0] = dram_data;
    end
  end

  varint_assemble u_assemble (
    .bytes     (asm_bytes),
    .raw       (raw),
    .len       (len),
    .malformed (malformed)
  );

  always_comb begin
    state_d   = state_q;
    dram_en   = '0;
    dram_addr = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (en) state_d = RD1;
      RD1, WAIT1: begin
        dram_en = 8'hFF;
        for (int i = 0; i < 8; i++) dram_addr[i] = src_q + ADDR_WIDTH'(i);
        if (state_q == RD1) state_d = WAIT1;
        else if (first_all_valid) state_d = term_in_first ? FIN : RD2;
      end
      RD2, WAIT2: begin
        dram_en      = 8'h03;
        dram_addr[0] = src_q + ADDR_WIDTH'(8);
        dram_addr[1] = src_q + ADDR_WIDTH'(9);
        if (state_q == RD2) state_d = WAIT2;
        else if (last_all_valid) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      type_q     <= '0;
      byte_q     <= '0;
      value      <= '0;
      bytes_read <= '0;
      error      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && en) begin
        src_q  <= src_addr;
        type_q <= field_type;
        error  <= 1'b0;
      end
      if (first_all_valid) byte_q <= dram_data;
      if (result_load) begin
        value      <= malformed ? 64'b0 : pb_post_process(raw, type_q);
        bytes_read <= malformed ? 4'd0 : len;
        error      <= malformed;
      end
    end
  end

endmodule

// File: tb/tb_top_varint_decode.sv
// tb/tb_top_varint_decode.sv - randomized and directed checks of top_varint_decode against a reference decoder
module tb_top_varint_decode;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic [63:0]       src_addr = '0;
  logic [4:0]        field_type = '0;
  logic [7:0]        dram_en;
  logic [7:0][63:0]  dram_addr;
  logic              dram_rdwr;
  logic [7:0][7:0]   dram_data;
  logic [7:0]        dram_valid;
  logic [63:0]       value;
  logic [3:0]        bytes_read;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  top_varint_decode #(.ADDR_WIDTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .src_addr   (src_addr),
    .field_type (field_type),
    .dram_en    (dram_en),
    .dram_addr  (dram_addr),
    .dram_rdwr  (dram_rdwr),
    .dram_data  (dram_data),
    .dram_valid (dram_valid),
    .value      (value),
    .bytes_read (bytes_read),
    .done       (done),
    .error      (error)
  );

  logic [63:0]  mem_base = '0;
  logic [7:0]   membuf [16];
  int unsigned  lat [8];
  int unsigned  en_cnt = 0;
  logic [7:0]   force_valid = '0;
  int           passed = 0;
  int           total = 0;

  always_ff @(posedge clk) en_cnt <= (dram_en == 8'h00) ? 0 : en_cnt + 1;

  always_comb begin
    logic [63:0] off;
    off = '0;
    for (int i = 0; i < 8; i++) begin
      off = dram_addr[i] - mem_base;
      dram_valid[i] = force_valid[i] | (dram_en[i] & (en_cnt >= lat[i]));
      dram_data[i]  = (dram_en[i] && off < 64'd16) ? membuf[off[3:0]] : 8'h5A;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    assert (got === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void ref_decode(input logic [7:0] b [10], input logic [4:0] t,
                                     output logic [63:0] v, output logic [3:0] n, output logic e);
    logic [63:0] raw, w, lo, z;
    int len;
    raw = 0; w = 1; len = 0;
    for (int k = 0; k < 10; k++) begin
      if (len == 0) begin
        raw = raw + 64'(b[k] % 8'd128) * w;
        w = w * 128;
        if (b[k] < 8'd128) len = k + 1;
      end
    end
    e = (len == 0) || (len == 10 && b[9] > 8'd1);
    lo = raw % 64'h1_0000_0000;
    case (t)
      5'd5, 5'd14: v = (lo >= 64'h8000_0000) ? lo + 64'hFFFF_FFFF_0000_0000 : lo;
      5'd13: v = lo;
      5'd18: v = (raw % 2 == 1) ? 64'd0 - raw / 2 - 1 : raw / 2;
      5'd17: begin
        z = (lo % 2 == 1) ? 64'h1_0000_0000 - lo / 2 - 1 : lo / 2;
        v = (z >= 64'h8000_0000) ? z + 64'hFFFF_FFFF_0000_0000 : z;
      end
      5'd8: v = (raw != 0) ? 64'd1 : 64'd0;
      default: v = raw;
    endcase
    n = 4'(len);
    if (e) begin
      v = 0;
      n = 0;
    end
  endfunction

  task automatic set_lat(input bit zero_wait, input bit stagger);
    for (int i = 0; i < 8; i++)
      lat[i] = zero_wait ? 0 : (stagger ? 1 + i % 4 : $urandom_range(0, 4));
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [4:0] t,
                        input logic [7:0] b [10], input bit zero_wait);
    logic [63:0] ev;
    logic [3:0]  en_n;
    logic        ee;
    bit          need_rd2, saw_rd2, bad, seen;
    int          cyc;
    ref_decode(b, t, ev, en_n, ee);
    need_rd2 = 1;
    for (int k = 0; k < 8; k++) if (b[k] < 8'd128) need_rd2 = 0;
    mem_base = a;
    for (int k = 0; k < 16; k++) membuf[k] = (k < 10) ? b[k] : 8'($urandom);
    @(negedge clk);
    en = 1'b1; src_addr = a; field_type = t;
    @(negedge clk);
    en = 1'b0; src_addr = {$urandom, $urandom}; field_type = 5'($urandom);
    cyc = 1;
    check({tag, "_rd1_en"}, 64'(dram_en), 64'hFF);
    check({tag, "_rd1_addr0"}, dram_addr[0], a);
    check({tag, "_rd1_addr7"}, dram_addr[7], a + 7);
    saw_rd2 = 0; bad = 0; seen = 0;
    while (cyc < 60) begin
      if (dram_rdwr !== 1'b0) bad = 1;
      if (dram_en == 8'hFF) begin
        for (int i = 0; i < 8; i++) if (dram_addr[i] != a + 64'(i)) bad = 1;
      end else if (dram_en == 8'h03) begin
        saw_rd2 = 1;
        if (dram_addr[0] != a + 8 || dram_addr[1] != a + 9) bad = 1;
        for (int i = 2; i < 8; i++) if (dram_addr[i] != 64'd0) bad = 1;
      end else if (dram_en != 8'h00) bad = 1;
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_port_stable"}, 64'(bad), 64'd0);
    check({tag, "_second_read"}, 64'(saw_rd2), 64'(need_rd2));
    if (zero_wait) check({tag, "_latency"}, 64'(cyc), need_rd2 ? 64'd5 : 64'd3);
    check({tag, "_value"}, value, ev);
    check({tag, "_bytes_read"}, 64'(bytes_read), 64'(en_n));
    check({tag, "_error"}, 64'(error), 64'(ee));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  logic [7:0] bv [10];
  logic [4:0] types [10] = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18, 5'd7, 5'd31};

  initial begin
    int mode, d1, d2, cyc;
    logic [63:0] a;
    set_lat(1, 0);
    for (int k = 0; k < 16; k++) membuf[k] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_value", value, 64'd0);
    check("reset_outs", {dram_en, 3'b0, bytes_read, done, error, dram_rdwr}, 64'd0);
    check("reset_addr", dram_addr[0] | dram_addr[7], 64'd0);
    reset = 1'b1;

    bv = '{8'h96, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_op("int32_150", 64'h100, 5'd5, bv, 1);
    bv = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_op("sint64_m2", 64'h140, 5'd18, bv, 1);
    run_op("sint32_m2", 64'h180, 5'd17, bv, 1);
    bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run_op("int32_m1", 64'h1C0, 5'd5, bv, 1);
    run_op("uint32_m1", 64'h1C0, 5'd13, bv, 1);
    bv[9] = 8'hFF;
    run_op("no_term", 64'h300, 5'd4, bv, 1);
    bv[9] = 8'h02;
    run_op("overflow", 64'h340, 5'd4, bv, 1);
    bv = '{8'hAC, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    set_lat(0, 1);
    run_op("bool_stagger", 64'h400, 5'd8, bv, 0);

    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(0, 11);
      for (int k = 0; k < 10; k++) bv[k] = 8'($urandom);
      if (mode <= 9) begin
        for (int k = 0; k < mode; k++) bv[k] = bv[k] | 8'h80;
        bv[mode] = (mode == 9) ? 8'($urandom_range(0, 1)) : bv[mode] & 8'h7F;
      end else begin
        for (int k = 0; k < 10; k++) bv[k] = bv[k] | 8'h80;
        if (mode == 11) bv[9] = 8'($urandom_range(2, 127));
      end
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      set_lat(r % 2 == 0, 0);
      run_op($sformatf("rand%0d", r), a, types[$urandom_range(0, 9)], bv, r % 2 == 0);
    end

    set_lat(1, 0);
    mem_base = 64'h500;
    membuf[0] = 8'h01;
    @(negedge clk);
    en = 1'b1; src_addr = 64'h500; field_type = 5'd4;
    d1 = 0; d2 = 0; cyc = 0;
    while (cyc < 40 && d2 == 0) begin
      @(negedge clk);
      cyc++;
      if (done && d1 == 0) d1 = cyc;
      else if (done) d2 = cyc;
    end
    en = 1'b0;
    check("busy_first_done", 64'(d1), 64'd3);
    check("busy_second_done", 64'(d2), 64'd7);
    @(negedge clk);

    for (int i = 0; i < 8; i++) lat[i] = 30;
    mem_base = 64'h600;
    @(negedge clk);
    en = 1'b1; src_addr = 64'h600; field_type = 5'd4;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_wait", 64'(dram_en), 64'hFF);
    reset = 1'b0;
    #1;
    check("rst_value", value, 64'd0);
    check("rst_outs", {dram_en, 3'b0, bytes_read, done, error, dram_rdwr}, 64'd0);
    check("rst_addr", dram_addr[0] | dram_addr[7], 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    force_valid = 8'hFF;
    d1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      force_valid = 8'h00;
      if (done || dram_en != 8'h00) d1++;
    end
    check("no_done_after_reset", 64'(d1), 64'd0);
    set_lat(1, 0);
    bv = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_op("after_reset", 64'h200, 5'd4, bv, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
